frame_sync: RTL and testbench

FRAME_SYNC -- requirements
Module: frame_sync

---
 rtl/frame_pkg.sv | 36 +++
 rtl/crc8_calc.sv | 31 +++
 rtl/frame_sync.sv | 201 ++++++++++++++++++++
 tb/tb_frame_sync.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared frame geometry, FAS pattern, CRC polynomial and FSM
// state encoding for the frame_sync block.
package frame_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 1041;
  localparam int FAS_LEN = 16;

  localparam logic [7:0] FAS_A = 8'hF6;
  localparam logic [7:0] FAS_B = 8'h28;
  localparam logic [FAS_LEN*8-1:0] FAS_PAT = {{8{FAS_A}}, {8{FAS_B}}};

  localparam int CRC_ROW = 3;
  localparam int CRC_COL = 1040;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] c_in,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_calc.sv
// crc8_calc: byte-wide CRC-8 accumulator (MSB first, init 0).
// Ports: i_clk, i_rst_n, i_clr (restart), i_en (absorb i_data), o_crc.
// Only built when FRAME_SYNC_CRC_EN is defined.
`ifdef FRAME_SYNC_CRC_EN
module crc8_calc
  import frame_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc8_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/frame_sync.sv
// frame_sync: 4x1041 frame aligner (HUNT/VERIFY/LOCKED) with payload
// extraction and optional CRC-8 check, enabled by macro FRAME_SYNC_CRC_EN.
// Ports: i_clk, i_rst_n, i_frame_data[7:0], i_frame_data_valid, i_cnt_clr,
// o_pyld_data[7:0], o_pyld_data_valid, o_row_cnt[1:0], o_col_cnt[10:0],
// o_frame_start, o_locked, o_crc_err, o_crc_err_cnt[CNT_W-1:0].
module frame_sync
  import frame_pkg::*;
#(
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_frame_data,
  input  logic             i_frame_data_valid,
  input  logic             i_cnt_clr,
  output logic [7:0]       o_pyld_data,
  output logic             o_pyld_data_valid,
  output logic [1:0]       o_row_cnt,
  output logic [10:0]      o_col_cnt,
  output logic             o_frame_start,
  output logic             o_locked,
  output logic             o_crc_err,
  output logic [CNT_W-1:0] o_crc_err_cnt
);

  localparam int MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT - 1);
  localparam logic [10:0] C_LAST = 11'(COLS - 1);
  localparam logic [10:0] C_FAS  = 11'(FAS_LEN - 1);
  localparam logic [10:0] C_CRC  = 11'(CRC_COL);
  localparam logic [1:0]  R_CRC  = 2'(CRC_ROW);

  state_t r_state;
  state_t w_state_nx;

  logic [FAS_LEN*8-1:0] r_sr;
  logic [FAS_LEN*8-1:0] w_sr;
  logic [1:0]           r_row;
  logic [1:0]           w_row_nx;
  logic [10:0]          r_col;
  logic [10:0]          w_col_nx;
  logic [MW-1:0]        r_miss;

  logic w_match;
  logic w_fas_pos;
  logic w_in_fas;
  logic w_is_crc;
  logic w_emit;
  logic w_fs;

  logic       r_pyld_valid;
  logic [7:0] r_pyld_data;
  logic       r_fs;

  // Oldest byte sits in the MSBs so the pattern reads left to right.
  assign w_sr    = {r_sr[FAS_LEN*8-9:0], i_frame_data};
  assign w_match = (w_sr == FAS_PAT);

  // Position of the byte currently on the input.
  assign w_col_nx = (r_col == C_LAST) ? 11'd0 : r_col + 11'd1;
  assign w_row_nx = (r_col == C_LAST) ? r_row + 2'd1 : r_row;

  assign w_in_fas  = (w_row_nx == 2'd0) && (w_col_nx <= C_FAS);
  assign w_fas_pos = (w_row_nx == 2'd0) && (w_col_nx == C_FAS);
  assign w_is_crc  = (w_row_nx == R_CRC) && (w_col_nx == C_CRC);

  always_comb begin
    w_state_nx = r_state;
    w_emit     = 1'b0;
    w_fs       = 1'b0;
    if (i_frame_data_valid) begin
      unique case (r_state)
        HUNT: begin
          if (w_match) w_state_nx = VERIFY;
        end
        VERIFY: begin
          if (w_fas_pos) begin
            if (w_match) begin
              w_state_nx = LOCKED;
              w_fs       = 1'b1;
            end else begin
              w_state_nx = HUNT;
            end
          end
        end
        LOCKED: begin
          w_emit = !w_in_fas && !w_is_crc;
          if (w_fas_pos) begin
            if (w_match) begin
              w_fs = 1'b1;
            end else if (r_miss == MISS_MAX) begin
              w_state_nx = HUNT;
            end
          end
        end
        default: w_state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
      r_sr    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (i_frame_data_valid) begin
        r_sr <= w_sr;
        if (r_state == HUNT) begin
          if (w_match) begin
            r_row <= 2'd0;
            r_col <= C_FAS;
          end
        end else begin
          r_row <= w_row_nx;
          r_col <= w_col_nx;
        end
        if (r_state != LOCKED || (w_fas_pos && w_match)) begin
          r_miss <= '0;
        end else if (w_fas_pos) begin
          r_miss <= (r_miss == MISS_MAX) ? '0 : r_miss + MW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pyld_valid <= 1'b0;
      r_pyld_data  <= '0;
      r_fs         <= 1'b0;
    end else begin
      r_pyld_valid <= w_emit;
      r_fs         <= w_fs;
      if (w_emit) r_pyld_data <= i_frame_data;
    end
  end

  assign o_pyld_data       = r_pyld_data;
  assign o_pyld_data_valid = r_pyld_valid;
  assign o_row_cnt         = r_row;
  assign o_col_cnt         = r_col;
  assign o_frame_start     = r_fs;
  assign o_locked          = (r_state == LOCKED);

`ifdef FRAME_SYNC_CRC_EN
  logic [7:0]       w_crc;
  logic             w_crc_clr;
  logic             w_crc_bad;
  logic             r_armed;
  logic             r_crc_err;
  logic [CNT_W-1:0] r_cnt;

  // Every FAS slot seen while aligned restarts the CRC; only a frame
  // whose FAS actually matched is armed for the check.
  assign w_crc_clr = i_frame_data_valid && w_fas_pos && (r_state != HUNT);
  assign w_crc_bad = i_frame_data_valid && (r_state == LOCKED) &&
                     w_is_crc && r_armed && (i_frame_data != w_crc);

  crc8_calc u_crc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_crc_clr),
    .i_en   (w_emit),
    .i_data (i_frame_data),
    .o_crc  (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed   <= 1'b0;
      r_crc_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_crc_err <= w_crc_bad;
      if (i_frame_data_valid) begin
        if (w_state_nx == HUNT) r_armed <= 1'b0;
        else if (w_crc_clr)     r_armed <= w_fs;
      end
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_crc_bad && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_crc_err     = r_crc_err;
  assign o_crc_err_cnt = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr  = i_cnt_clr;
  assign o_crc_err     = 1'b0;
  assign o_crc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: directed bench for frame_sync (lock, CRC, FAS loss,
// throttled input, async reset, counter saturation with CNT_W=2).
module tb_frame_sync;

  localparam int COLS = 1041;
  localparam int FB   = 4 * COLS;
  localparam int NPAY = FB - 17;
  localparam int MID  = 2 * COLS + 500;
`ifdef FRAME_SYNC_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_frame_data;
  logic        i_frame_data_valid;
  logic        i_cnt_clr;
  logic [7:0]  o_pyld_data;
  logic        o_pyld_data_valid;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_frame_start;
  logic        o_locked;
  logic        o_crc_err;
  logic [1:0]  o_crc_err_cnt;

  frame_sync #(.MISS_LIMIT(3), .CNT_W(2)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_frame_data      (i_frame_data),
    .i_frame_data_valid(i_frame_data_valid),
    .i_cnt_clr         (i_cnt_clr),
    .o_pyld_data       (o_pyld_data),
    .o_pyld_data_valid (o_pyld_data_valid),
    .o_row_cnt         (o_row_cnt),
    .o_col_cnt         (o_col_cnt),
    .o_frame_start     (o_frame_start),
    .o_locked          (o_locked),
    .o_crc_err         (o_crc_err),
    .o_crc_err_cnt     (o_crc_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_crc;

  int         w_cnt = 0;
  logic [7:0] w_crc = '0;
  int         last_cnt = 0;
  logic [7:0] last_crc = '0;
  int         fs_total = 0;
  int         err_total = 0;
  int         bad_pyld = 0;

  // Bit-serial reference CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crcb(input logic [7:0] c_in,
                                      input logic [7:0] d);
    logic [7:0] c;
    logic       f;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      f = c[7] ^ d[i];
      c = {c[6:0], 1'b0};
      if (f) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [7:0] pay(input int r, input int c);
    return 8'(r * 64 + c * 3 + (c >> 5));
  endfunction

  function automatic logic [7:0] fbyte(input int r, input int c,
                                       input bit fas_bad,
                                       input bit pay_bad);
    logic [7:0] v;
    if (r == 0 && c < 16) begin
      v = (c < 8) ? 8'hF6 : 8'h28;
      if (fas_bad && c == 3) v = 8'h00;
    end else if (r == 3 && c == COLS - 1) begin
      v = exp_crc;
    end else begin
      v = pay(r, c);
      if (pay_bad && r == 1 && c == 100) v = v ^ 8'h5A;
    end
    return v;
  endfunction

  // Payload window between consecutive frame-start pulses.
  always @(negedge i_clk) begin
    if (o_pyld_data_valid) begin
      w_cnt = w_cnt + 1;
      w_crc = crcb(w_crc, o_pyld_data);
      if (!o_locked) bad_pyld = bad_pyld + 1;
    end
    if (o_frame_start) begin
      fs_total = fs_total + 1;
      last_cnt = w_cnt;
      last_crc = w_crc;
      w_cnt = 0;
      w_crc = '0;
    end
    if (o_crc_err) err_total = err_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [7:0] d, input logic v, input logic clr);
    i_frame_data       = d;
    i_frame_data_valid = v;
    i_cnt_clr          = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit fas_bad,
                      input bit pay_bad, input bit half, input bit clr);
    int r;
    int c;
    for (int k = a; k < b; k++) begin
      r = k / COLS;
      c = k % COLS;
      if (half) drv(8'($urandom), 1'b0, 1'b0);
      drv(fbyte(r, c, fas_bad, pay_bad), 1'b1,
          clr && r == 3 && c == COLS - 1);
    end
    i_frame_data_valid = 1'b0;
    i_cnt_clr          = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached, observed %0d compared",
             n_cmp);
    $fatal(1, "time limit");
  end

  initial begin
    exp_crc = '0;
    for (int k = 0; k < FB; k++) begin
      if (!((k < 16) || (k == FB - 1)))
        exp_crc = crcb(exp_crc, pay(k / COLS, k % COLS));
    end

    i_rst_n            = 1'b0;
    i_frame_data       = '0;
    i_frame_data_valid = 1'b0;
    i_cnt_clr          = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_pvalid", 32'(o_pyld_data_valid), 0);
    chk("rst_fs", 32'(o_frame_start), 0);
    chk("rst_cnt", 32'(o_crc_err_cnt), 0);
    chk("rst_row", 32'(o_row_cnt), 0);
    chk("rst_col", 32'(o_col_cnt), 0);
    i_rst_n = 1'b1;

    for (int k = 0; k < 5; k++) drv(8'(k * 17 + 1), 1'b1, 1'b0);

    send(0, FB, 0, 0, 0, 0);
    chk("f1_locked", 32'(o_locked), 0);
    chk("f1_fs", 32'(fs_total), 0);
    send(0, FB, 0, 0, 0, 0);
    chk("f2_locked", 32'(o_locked), 1);
    chk("f2_fs", 32'(fs_total), 1);
    send(0, FB, 0, 0, 0, 0);
    chk("f3_fs", 32'(fs_total), 2);
    chk("f3_pcnt", 32'(last_cnt), 32'(NPAY));
    chk("f3_pcrc", 32'(last_crc), 32'(exp_crc));
    chk("f3_err", 32'(o_crc_err), 0);
    chk("f3_errtot", 32'(err_total), 0);

    send(0, FB, 0, 1, 0, 0);
    chk("f4_err", 32'(o_crc_err), 32'(CRC_ON));
    chk("f4_cnt", 32'(o_crc_err_cnt), CRC_ON ? 1 : 0);
    chk("f4_locked", 32'(o_locked), 1);
    drv(8'h00, 1'b0, 1'b0);
    chk("f4_err_end", 32'(o_crc_err), 0);

    send(0, FB, 0, 1, 0, 0);
    chk("f5_cnt", 32'(o_crc_err_cnt), CRC_ON ? 2 : 0);
    send(0, FB, 0, 1, 0, 0);
    chk("f6_cnt", 32'(o_crc_err_cnt), CRC_ON ? 3 : 0);
    send(0, FB, 0, 1, 0, 0);
    chk("f7_cnt_sat", 32'(o_crc_err_cnt), CRC_ON ? 3 : 0);
    send(0, FB, 0, 1, 0, 1);
    chk("f8_cnt_clr", 32'(o_crc_err_cnt), 0);
    chk("f8_errtot", 32'(err_total), CRC_ON ? 5 : 0);
    chk("f8_locked", 32'(o_locked), 1);

    send(0, FB, 1, 0, 0, 0);
    chk("miss1_locked", 32'(o_locked), 1);
    send(0, FB, 1, 0, 0, 0);
    chk("miss2_locked", 32'(o_locked), 1);
    send(0, FB, 1, 0, 0, 0);
    chk("miss3_locked", 32'(o_locked), 0);
    send(0, FB, 0, 0, 0, 0);
    chk("relock1", 32'(o_locked), 0);
    send(0, FB, 0, 0, 0, 0);
    chk("relock2", 32'(o_locked), 1);
    chk("relock_errtot", 32'(err_total), CRC_ON ? 5 : 0);

    send(0, FB, 0, 0, 1, 0);
    chk("full_pcnt", 32'(last_cnt), 32'(NPAY));
    chk("full_pcrc", 32'(last_crc), 32'(exp_crc));
    chk("half_err", 32'(err_total), CRC_ON ? 5 : 0);

    send(0, 16, 0, 0, 0, 0);
    chk("fs_pulse", 32'(o_frame_start), 1);
    send(16, MID, 0, 0, 0, 0);
    chk("half_pcnt", 32'(last_cnt), 32'(NPAY));
    chk("half_pcrc", 32'(last_crc), 32'(exp_crc));
    chk("mid_pvalid", 32'(o_pyld_data_valid), 1);
    chk("mid_pdata", 32'(o_pyld_data), 32'(pay(2, 499)));
    chk("mid_row", 32'(o_row_cnt), 2);
    chk("mid_col", 32'(o_col_cnt), 499);

    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_pvalid", 32'(o_pyld_data_valid), 0);
    chk("arst_pdata", 32'(o_pyld_data), 0);
    chk("arst_locked", 32'(o_locked), 0);
    chk("arst_row", 32'(o_row_cnt), 0);
    chk("arst_col", 32'(o_col_cnt), 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    send(MID, FB, 0, 0, 0, 0);
    chk("post_rst_locked", 32'(o_locked), 0);
    send(0, FB, 0, 0, 0, 0);
    chk("post_rst_verify", 32'(o_locked), 0);
    send(0, FB, 0, 0, 0, 0);
    chk("post_rst_relock", 32'(o_locked), 1);
    chk("no_pyld_unlocked", 32'(bad_pyld), 0);
    chk("post_rst_cnt", 32'(o_crc_err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
